transition_pair_sequencer: RTL and testbench
============================================

TRANSITION_PAIR_SEQUENCER -- requirements
Module: transition_pair_sequencer

Interface
REQ-001 Parameter NVEC, default 16: number of input vectors applied to the gate-under-test; legal values 2, 4, 8, 16.
REQ-002 Parameter HOLD, default 5: clock cycles each vector is held; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  begin a full sweep; sampled only in IDLE.
REQ-006 abort  input  1  terminate the sweep; sampled in every non-IDLE state.
REQ-007 cap_ready  input  1  trace-capture side ready to accept the next pair.
REQ-008 vec  output  4  stimulus {a,b,r1,r2} driven to the gate-under-test, registered.
REQ-009 sim_idx  output  8  index of the current pair, i*NVEC+j.
REQ-010 trig_begin  output  1  one-cycle pulse marking the start of the to-vector phase.
REQ-011 trig_end  output  1  one-cycle pulse marking the end of the to-vector phase.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse on sweep completion.

Function
REQ-014 The block SHALL apply every ordered pair (i, j), i and j in 0..NVEC-1, as the from-vector i followed by the to-vector j, with j as the inner loop and i as the outer loop.
REQ-015 State set: IDLE, PRE, POST, WAIT, DONE.
REQ-016 IDLE with start=1: next cycle enters PRE with i=0, j=0, vec=0, sim_idx=0, and hold counter 0.
REQ-017 PRE: vec=i for exactly HOLD cycles; on the last cycle, transition to POST.
REQ-018 POST: vec=j for exactly HOLD cycles; trig_begin=1 on the first POST cycle only; on the last cycle, transition to WAIT.
REQ-019 WAIT: vec holds j; trig_end=1 on the first WAIT cycle only; remains in WAIT while cap_ready=0.
REQ-020 WAIT with cap_ready=1, including on the first WAIT cycle: if j<NVEC-1, then j++ and go to PRE; else j=0 and, if i<NVEC-1, then i++ and go to PRE; else go to DONE.
REQ-021 sim_idx SHALL update on PRE entry and stay stable through PRE, POST and WAIT.
REQ-022 Minimum cycles per pair: 2*HOLD+1; with cap_ready held high, a sweep occupies NVEC*NVEC*(2*HOLD+1) cycles from first PRE to DONE.
REQ-023 DONE: lasts one cycle with done=1 and vec=0, then returns to IDLE.
REQ-024 start while busy=1 SHALL be ignored.
REQ-025 abort=1 in PRE, POST, WAIT or DONE: next cycle enters IDLE with vec=0, i=j=0, no trig_begin, no trig_end, no done; abort has priority over cap_ready.
REQ-026 start and abort both high in IDLE: start is honoured, and abort is ignored because it is not sampled in IDLE.
REQ-027 When i==j, the pair is still applied in full (PRE, POST and WAIT phases, and both triggers).
REQ-028 vec[3:log2(NVEC)] SHALL be 0 when NVEC<16.
REQ-029 trig_begin and trig_end SHALL never be high in the same cycle.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, vec=0, sim_idx=0, i=j=0, hold counter 0, and busy=done=trig_begin=trig_end=0, regardless of clk.
REQ-031 Reset asserted mid-sweep SHALL discard all progress; the next start begins again at pair (0,0).
REQ-032 Release of rst SHALL not by itself start a sweep; start is required.

Verification
REQ-033 Reset mid-POST at pair (3,7) -> all outputs 0 asynchronously; start after release -> first PRE shows vec=0, sim_idx=0.
REQ-034 NVEC=16, HOLD=5, cap_ready=1, single start pulse -> 256 trig_begin pulses, 256 trig_end pulses, done 2816 cycles after the first PRE cycle, and sim_idx covering 0..255 in order.
REQ-035 Pair (2,9) with HOLD=5 -> vec=2 for 5 cycles, then vec=9 for 5 cycles with trig_begin on the first of them, then trig_end, and sim_idx=41 throughout.
REQ-036 cap_ready=0 for 20 cycles in WAIT at pair (0,15) -> vec stays 15, no new trig pulses; on cap_ready=1 -> next PRE has vec=1, sim_idx=16.
REQ-037 abort during PRE of pair (5,5) -> IDLE next cycle, vec=0, busy=0, done never asserted; start pulse during a sweep -> no restart, sim_idx sequence unbroken.
REQ-038 NVEC=4, HOLD=1, cap_ready=1 -> 16 pairs, done 48 cycles after the first PRE cycle, vec[3:2]=0 throughout.

Source files
------------

// File: rtl/transition_pair_sequencer.sv
// Transition-pair stimulus sequencer: walks every ordered (from, to) vector
// pair through a gate-under-test, with trigger pulses framing each to-phase.
module transition_pair_sequencer #(
  parameter int NVEC = 16,
  parameter int HOLD = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       cap_ready,
  output logic [3:0] vec,
  output logic [7:0] sim_idx,
  output logic       trig_begin,
  output logic       trig_end,
  output logic       busy,
  output logic       done
);

  localparam int IW = $clog2(NVEC);
  localparam logic [IW-1:0] LAST = IW'(NVEC - 1);
  localparam logic [7:0] HLAST = 8'(HOLD - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    POST,
    WAIT,
    DONE
  } state_t;

  state_t state, state_n;

  logic [IW-1:0] i, i_n;
  logic [IW-1:0] j, j_n;
  logic [7:0]    cnt, cnt_n;
  logic [3:0]    vec_n;
  logic [7:0]    idx_n;
  logic          tb_n, te_n, done_n;
  logic          last_pair;

  assign last_pair = (i == LAST) && (j == LAST);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      i          <= '0;
      j          <= '0;
      cnt        <= '0;
      vec        <= '0;
      sim_idx    <= '0;
      trig_begin <= 1'b0;
      trig_end   <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      i          <= i_n;
      j          <= j_n;
      cnt        <= cnt_n;
      vec        <= vec_n;
      sim_idx    <= idx_n;
      trig_begin <= tb_n;
      trig_end   <= te_n;
      done       <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    i_n     = i;
    j_n     = j;
    cnt_n   = cnt;
    vec_n   = vec;
    idx_n   = sim_idx;
    tb_n    = 1'b0;
    te_n    = 1'b0;
    done_n  = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = PRE;
          i_n     = '0;
          j_n     = '0;
          cnt_n   = '0;
          vec_n   = '0;
          idx_n   = '0;
        end
      end

      PRE: begin
        if (cnt == HLAST) begin
          state_n = POST;
          cnt_n   = '0;
          vec_n   = 4'(j);
          tb_n    = 1'b1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end

      POST: begin
        if (cnt == HLAST) begin
          state_n = WAIT;
          cnt_n   = '0;
          te_n    = 1'b1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end

      WAIT: begin
        if (cap_ready) begin
          cnt_n = '0;
          if (last_pair) begin
            state_n = DONE;
            i_n     = '0;
            j_n     = '0;
            vec_n   = '0;
            idx_n   = '0;
            done_n  = 1'b1;
          end else begin
            state_n = PRE;
            if (j == LAST) begin
              j_n = '0;
              i_n = i + 1'b1;
            end else begin
              j_n = j + 1'b1;
            end
            vec_n = 4'(i_n);
            idx_n = 8'({i_n, j_n});
          end
        end
      end

      DONE: begin
        state_n = IDLE;
        vec_n   = '0;
        idx_n   = '0;
      end

      default: begin
        state_n = IDLE;
        vec_n   = '0;
        idx_n   = '0;
      end
    endcase

    // abort wins over everything, including cap_ready and the DONE pulse
    if (state != IDLE && abort) begin
      state_n = IDLE;
      i_n     = '0;
      j_n     = '0;
      cnt_n   = '0;
      vec_n   = '0;
      idx_n   = '0;
      tb_n    = 1'b0;
      te_n    = 1'b0;
      done_n  = 1'b0;
    end
  end

endmodule

// File: tb/tb_transition_pair_sequencer.sv
// Bench for transition_pair_sequencer: pair-level reference model,
// directed corner sequences, a small vector table and random traffic.
module tb_transition_pair_sequencer;

  localparam int NV = 16;
  localparam int HD = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, abort = 1'b0, cap_ready = 1'b0;
  logic [3:0] vec;
  logic [7:0] sim_idx;
  logic       trig_begin, trig_end, busy, done;

  logic       start4 = 1'b0, abort4 = 1'b0, cap4 = 1'b0;
  logic [3:0] vec4;
  logic [7:0] idx4;
  logic       tb4, te4, busy4, done4;

  int n_chk  = 0;
  int n_fail = 0;

  // model: pair number p, cycle offset t inside the pair
  bit m_active = 1'b0;
  bit m_done   = 1'b0;
  int m_p = 0;
  int m_t = 0;

  always #5 clk = ~clk;

  transition_pair_sequencer #(.NVEC(NV), .HOLD(HD)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cap_ready(cap_ready), .vec(vec), .sim_idx(sim_idx),
    .trig_begin(trig_begin), .trig_end(trig_end),
    .busy(busy), .done(done)
  );

  transition_pair_sequencer #(.NVEC(4), .HOLD(1)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .abort(abort4),
    .cap_ready(cap4), .vec(vec4), .sim_idx(idx4),
    .trig_begin(tb4), .trig_end(te4),
    .busy(busy4), .done(done4)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_done   = 1'b0;
    m_p      = 0;
    m_t      = 0;
  endtask

  task automatic model_step(input bit s, input bit a, input bit c);
    if (m_done) begin
      m_done = 1'b0;
    end else if (!m_active) begin
      if (s) begin
        m_active = 1'b1;
        m_p = 0;
        m_t = 0;
      end
    end else if (a) begin
      m_active = 1'b0;
    end else if (m_t >= 2 * HD && c) begin
      if (m_p == NV * NV - 1) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end else begin
        m_p++;
        m_t = 0;
      end
    end else begin
      m_t++;
    end
  endtask

  task automatic cycle(input bit s, input bit a, input bit c);
    int ev;
    @(negedge clk);
    start = s; abort = a; cap_ready = c;
    @(posedge clk);
    model_step(s, a, c);
    #1;
    chk("busy", busy, 32'(m_active || m_done));
    chk("done", done, 32'(m_done));
    if (m_active) begin
      ev = (m_t < HD) ? m_p / NV : m_p % NV;
      chk("vec", vec, ev);
      chk("sim_idx", sim_idx, m_p);
      chk("trig_begin", trig_begin, 32'(m_t == HD));
      chk("trig_end", trig_end, 32'(m_t == 2 * HD));
    end else begin
      chk("vec_idle", vec, 0);
      chk("trig_begin_idle", trig_begin, 0);
      chk("trig_end_idle", trig_end, 0);
    end
  endtask

  task automatic cycle4(input bit s, input bit a, input bit c);
    @(negedge clk);
    start4 = s; abort4 = a; cap4 = c;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit s, a, c;
    logic [3:0] v;
    logic [7:0] idx;
    bit tb, te, bz, dn;
  } row_t;

  row_t tbl[10];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit found;
    int nb, ne, done_at, lo, hi;
    logic [5:0] q41[$];
    logic [5:0] e41;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 4'd0, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 4'd1, 8'd1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 4'd1, 8'd1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};

    // reset state
    #2;
    chk("rst_vec", vec, 0);
    chk("rst_idx", sim_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_trig", {trig_begin, trig_end}, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // release alone does not start a sweep
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);

    // stall in WAIT at pair (0,15)
    cycle(1'b1, 1'b0, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      cycle(1'b0, 1'b0, 1'b1);
      found = (m_p == 15 && m_t == 2 * HD);
    end
    chk("reach_wait_0_15", 32'(found), 1);
    chk("wait_first_te", trig_end, 1);
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, 1'b0, 1'b0);
      chk("stall_vec", vec, 15);
      chk("stall_trig", {trig_begin, trig_end}, 0);
    end
    cycle(1'b0, 1'b0, 1'b1);
    chk("resume_vec", vec, 1);
    chk("resume_idx", sim_idx, 16);

    // start pulses mid-sweep are ignored; abort in PRE of (5,5)
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      cycle(1'((k % 7) == 3), 1'b0, 1'b1);
      found = (m_p == 85 && m_t == 2);
    end
    chk("reach_pre_5_5", 32'(found), 1);
    cycle(1'b0, 1'b1, 1'b1);
    chk("abort_busy", busy, 0);
    chk("abort_vec", vec, 0);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b0, 1'b1);
      chk("abort_no_done", done, 0);
    end

    // full sweep with cap_ready held high
    nb = 0; ne = 0; done_at = -1;
    cycle(1'b1, 1'b0, 1'b1);
    for (int k = 1; k < 3000 && done_at < 0; k++) begin
      cycle(1'b0, 1'b0, 1'b1);
      if (busy && sim_idx == 8'd41 && !done)
        q41.push_back({trig_end, trig_begin, vec});
      if (trig_begin) begin
        chk("idx_order", sim_idx, nb);
        nb++;
      end
      if (trig_end) ne++;
      if (done) done_at = k;
    end
    chk("sweep_tb_count", nb, 256);
    chk("sweep_te_count", ne, 256);
    chk("sweep_done_at", done_at, 2816);
    chk("pair41_len", q41.size(), 11);
    for (int k = 0; k < 11 && k < q41.size(); k++) begin
      e41 = {1'b0, 1'b0, 4'(k < 5 ? 2 : 9)};
      if (k == 5)  e41[4] = 1'b1;
      if (k == 10) e41[5] = 1'b1;
      chk("pair41_seq", q41[k], e41);
    end
    cycle(1'b0, 1'b0, 1'b1);

    // asynchronous reset mid-POST of pair (3,7)
    cycle(1'b1, 1'b0, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 1000 && !found; k++) begin
      cycle(1'b0, 1'b0, 1'b1);
      found = (m_p == 55 && m_t == HD + 2);
    end
    chk("reach_post_3_7", 32'(found), 1);
    @(negedge clk);
    start = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_vec", vec, 0);
    chk("arst_idx", sim_idx, 0);
    chk("arst_busy", busy, 0);
    chk("arst_flags", {trig_begin, trig_end, done}, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    chk("restart_vec", vec, 0);
    chk("restart_idx", sim_idx, 0);
    chk("restart_busy", busy, 1);

    // random traffic against the model
    for (int k = 0; k < 3000; k++)
      cycle(1'(($urandom % 8) == 0), 1'(($urandom % 64) == 0),
            1'($urandom % 2));
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);

    // vector table, NVEC=4 HOLD=1
    for (int r = 0; r < 10; r++) begin
      cycle4(tbl[r].s, tbl[r].a, tbl[r].c);
      chk($sformatf("tbl%0d_vec", r), vec4, tbl[r].v);
      chk($sformatf("tbl%0d_tb", r), tb4, tbl[r].tb);
      chk($sformatf("tbl%0d_te", r), te4, tbl[r].te);
      chk($sformatf("tbl%0d_busy", r), busy4, tbl[r].bz);
      chk($sformatf("tbl%0d_done", r), done4, tbl[r].dn);
      if (tbl[r].bz)
        chk($sformatf("tbl%0d_idx", r), idx4, tbl[r].idx);
    end

    // full sweep, NVEC=4 HOLD=1
    nb = 0; done_at = -1; hi = 0; lo = 0;
    cycle4(1'b1, 1'b0, 1'b1);
    for (int k = 1; k < 200 && done_at < 0; k++) begin
      cycle4(1'b0, 1'b0, 1'b1);
      if (vec4[3:2] != 2'b00) hi++;
      if (tb4) begin
        if (idx4 != 8'(nb)) lo++;
        nb++;
      end
      if (done4) done_at = k;
    end
    chk("n4_done_at", done_at, 48);
    chk("n4_tb_count", nb, 16);
    chk("n4_vec_high_zero", hi, 0);
    chk("n4_idx_order", lo, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
